eth_cmd_decoder: RTL and testbench

Consumes the CRC-checked 10-bit Ethernet stream leaving the 2048-byte RX packet buffer and turns host command frames into register-write strobes for the filter control interface. Checks destination MAC and EtherType, parses a record count followed by address/data records, and emits one write per completed record. Its BUSY output gates the buffer's OUT_GO so that only one frame is in flight at a time.

---
 rtl/eth_cmd_decoder.sv | 203 ++++++++++++++++++++
 tb/tb_eth_cmd_decoder.sv | 464 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_cmd_decoder.sv
`default_nettype none
// ============================================================================
// Module   : eth_cmd_decoder
// Brief    : Turns host command frames from the RX packet buffer into
//            register-write strobes for the filter control interface.
// Revision : 1.0 - initial release
// ============================================================================
module eth_cmd_decoder #(
  parameter logic [47:0] MY_MAC        = 48'h0050C2AE4001,
  parameter logic [15:0] CMD_ETHERTYPE = 16'h88B5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [9:0]  i_eth_stream,
  output logic        o_busy,
  output logic        o_wr_en,
  output logic [7:0]  o_wr_addr,
  output logic [31:0] o_wr_data,
  output logic        o_pkt_ok,
  output logic        o_pkt_err,
  output logic [15:0] o_drop_cnt
);

  localparam logic [10:0] C_BCNT_MAX = 11'd2047;
  localparam logic [10:0] C_LAST_HDR = 11'd13;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HDR   = 3'd1,
    S_CNT   = 3'd2,
    S_REC   = 3'd3,
    S_DRAIN = 3'd4
  } state_t;

  state_t      r_state;
  logic [10:0] r_bcnt;
  logic [7:0]  r_rec_cnt;
  logic [7:0]  r_rec_n;
  logic [2:0]  r_ridx;
  logic [31:0] r_shift;
  logic        r_my_match;
  logic        r_bc_match;
  logic        r_et_match;
  logic        r_ok_flag;
  logic        r_drop_flag;

  logic        r_busy;
  logic        r_wr_en;
  logic [7:0]  r_wr_addr;
  logic [31:0] r_wr_data;
  logic        r_pkt_ok;
  logic        r_pkt_err;
  logic [15:0] r_drop_cnt;

  logic        w_cke;
  logic        w_frm;
  logic [7:0]  w_dat;
  logic        w_byte;
  logic        w_eof;
  logic [10:0] w_idx;
  logic [7:0]  w_mac_byte;
  logic [7:0]  w_et_byte;
  logic        w_in_mac;
  logic        w_in_et;
  logic        w_my_hit;
  logic        w_bc_hit;
  logic        w_et_hit;
  logic        w_hdr_match;

  assign w_cke  = i_eth_stream[9];
  assign w_frm  = i_eth_stream[8];
  assign w_dat  = i_eth_stream[7:0];
  assign w_byte = w_cke && w_frm;
  assign w_eof  = w_cke && !w_frm && (r_state != S_IDLE);

  // The byte sampled in IDLE is always b0; afterwards r_bcnt holds its index.
  assign w_idx = (r_state == S_IDLE) ? 11'd0 : r_bcnt;

  always_comb begin
    w_mac_byte = 8'h00;
    w_et_byte  = 8'h00;
    w_in_mac   = 1'b0;
    w_in_et    = 1'b0;
    case (w_idx)
      11'd0:   begin w_mac_byte = MY_MAC[47:40]; w_in_mac = 1'b1; end
      11'd1:   begin w_mac_byte = MY_MAC[39:32]; w_in_mac = 1'b1; end
      11'd2:   begin w_mac_byte = MY_MAC[31:24]; w_in_mac = 1'b1; end
      11'd3:   begin w_mac_byte = MY_MAC[23:16]; w_in_mac = 1'b1; end
      11'd4:   begin w_mac_byte = MY_MAC[15:8];  w_in_mac = 1'b1; end
      11'd5:   begin w_mac_byte = MY_MAC[7:0];   w_in_mac = 1'b1; end
      11'd12:  begin w_et_byte = CMD_ETHERTYPE[15:8]; w_in_et = 1'b1; end
      11'd13:  begin w_et_byte = CMD_ETHERTYPE[7:0];  w_in_et = 1'b1; end
      default: ;
    endcase
  end

  assign w_my_hit    = !w_in_mac || (w_dat == w_mac_byte);
  assign w_bc_hit    = !w_in_mac || (w_dat == 8'hFF);
  assign w_et_hit    = !w_in_et  || (w_dat == w_et_byte);
  assign w_hdr_match = ((r_my_match && w_my_hit) || (r_bc_match && w_bc_hit))
                       && r_et_match && w_et_hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_bcnt      <= 11'd0;
      r_rec_cnt   <= 8'd0;
      r_rec_n     <= 8'd0;
      r_ridx      <= 3'd0;
      r_shift     <= 32'd0;
      r_my_match  <= 1'b0;
      r_bc_match  <= 1'b0;
      r_et_match  <= 1'b0;
      r_ok_flag   <= 1'b0;
      r_drop_flag <= 1'b0;
      r_busy      <= 1'b0;
      r_wr_en     <= 1'b0;
      r_wr_addr   <= 8'd0;
      r_wr_data   <= 32'd0;
      r_pkt_ok    <= 1'b0;
      r_pkt_err   <= 1'b0;
      r_drop_cnt  <= 16'd0;
    end else begin
      r_wr_en   <= 1'b0;
      r_pkt_ok  <= 1'b0;
      r_pkt_err <= 1'b0;
      if (w_eof) begin
        if (r_ok_flag)        r_pkt_ok   <= 1'b1;
        else if (r_drop_flag) r_drop_cnt <= r_drop_cnt + 16'd1;
        else                  r_pkt_err  <= 1'b1;
        r_state     <= S_IDLE;
        r_ok_flag   <= 1'b0;
        r_drop_flag <= 1'b0;
        r_busy      <= 1'b0;
      end else if (w_byte) begin
        if (r_bcnt != C_BCNT_MAX) r_bcnt <= r_bcnt + 11'd1;
        case (r_state)
          S_IDLE: begin
            r_state    <= S_HDR;
            r_bcnt     <= 11'd1;
            r_my_match <= w_my_hit;
            r_bc_match <= w_bc_hit;
            r_et_match <= 1'b1;
            r_busy     <= 1'b1;
          end
          S_HDR: begin
            r_my_match <= r_my_match && w_my_hit;
            r_bc_match <= r_bc_match && w_bc_hit;
            r_et_match <= r_et_match && w_et_hit;
            if (r_bcnt == C_LAST_HDR) begin
              if (w_hdr_match) begin
                r_state <= S_CNT;
              end else begin
                r_state     <= S_DRAIN;
                r_drop_flag <= 1'b1;
              end
            end
          end
          S_CNT: begin
            r_rec_n   <= w_dat;
            r_rec_cnt <= 8'd0;
            r_ridx    <= 3'd0;
            if (w_dat == 8'd0) begin
              r_state   <= S_DRAIN;
              r_ok_flag <= 1'b1;
            end else begin
              r_state <= S_REC;
            end
          end
          S_REC: begin
            // Address byte lands in the top of the shifter, data bytes follow.
            r_shift <= {r_shift[23:0], w_dat};
            if (r_ridx == 3'd4) begin
              r_ridx    <= 3'd0;
              r_wr_en   <= 1'b1;
              r_wr_addr <= r_shift[31:24];
              r_wr_data <= {r_shift[23:0], w_dat};
              r_rec_cnt <= r_rec_cnt + 8'd1;
              if ((r_rec_cnt + 8'd1) == r_rec_n) begin
                r_state   <= S_DRAIN;
                r_ok_flag <= 1'b1;
              end
            end else begin
              r_ridx <= r_ridx + 3'd1;
            end
          end
          S_DRAIN: ;
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign o_busy     = r_busy;
  assign o_wr_en    = r_wr_en;
  assign o_wr_addr  = r_wr_addr;
  assign o_wr_data  = r_wr_data;
  assign o_pkt_ok   = r_pkt_ok;
  assign o_pkt_err  = r_pkt_err;
  assign o_drop_cnt = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_eth_cmd_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_eth_cmd_decoder
// Brief    : Self-checking bench for eth_cmd_decoder with a frame-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_eth_cmd_decoder;

  localparam logic [47:0] C_MY_MAC = 48'h0050C2AE4001;
  localparam logic [47:0] C_BCAST  = 48'hFFFFFFFFFFFF;
  localparam logic [15:0] C_ET     = 16'h88B5;
  localparam int          C_EV_OK  = 1 << 24;
  localparam int          C_EV_ERR = 2 << 24;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [9:0]  i_eth_stream = 10'd0;
  logic        o_busy, o_wr_en, o_pkt_ok, o_pkt_err;
  logic [7:0]  o_wr_addr;
  logic [31:0] o_wr_data;
  logic [15:0] o_drop_cnt;

  eth_cmd_decoder dut (
    .clk         (clk),
    .rst         (rst),
    .i_eth_stream(i_eth_stream),
    .o_busy      (o_busy),
    .o_wr_en     (o_wr_en),
    .o_wr_addr   (o_wr_addr),
    .o_wr_data   (o_wr_data),
    .o_pkt_ok    (o_pkt_ok),
    .o_pkt_err   (o_pkt_err),
    .o_drop_cnt  (o_drop_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  bit rst_seen = 1'b1;
  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_seen <= rst;
  end

  int          n_chk = 0;
  int          n_fail = 0;
  logic [7:0]  frm_q[$];
  int          byte_cyc[$];
  int          eof_cyc;
  logic [7:0]  exp_addr[$], got_addr[$];
  logic [31:0] exp_data[$], got_data[$];
  int          exp_wcyc[$], got_wcyc[$];
  int          exp_evt[$], got_evt[$];
  int          exp_drop = 0;
  int          busy_first, busy_last;
  bit          busy_seen;
  int          hold_viol = 0;
  logic [7:0]  prev_addr = 8'd0;
  logic [31:0] prev_data = 32'd0;

  // Observer: collects write strobes, end-of-frame pulses and BUSY extent.
  always @(negedge clk) begin
    if (o_wr_en) begin
      got_addr.push_back(o_wr_addr);
      got_data.push_back(o_wr_data);
      got_wcyc.push_back(cyc);
    end
    if (o_pkt_ok)  got_evt.push_back(C_EV_OK + cyc);
    if (o_pkt_err) got_evt.push_back(C_EV_ERR + cyc);
    if (o_busy) begin
      if (!busy_seen) busy_first = cyc;
      busy_seen = 1'b1;
      busy_last = cyc;
    end
    if (!rst_seen && !o_wr_en && (o_wr_addr !== prev_addr || o_wr_data !== prev_data))
      hold_viol++;
    prev_addr = o_wr_addr;
    prev_data = o_wr_data;
  end

  task automatic clear_sb();
    exp_addr.delete(); exp_data.delete(); exp_wcyc.delete(); exp_evt.delete();
    got_addr.delete(); got_data.delete(); got_wcyc.delete(); got_evt.delete();
    busy_seen = 1'b0;
    hold_viol = 0;
  endtask

  task automatic drive(input bit cke, input bit frm, input logic [7:0] dat);
    @(posedge clk);
    #2;
    i_eth_stream = {cke, frm, dat};
  endtask

  // Stalled cycles carry random FRM/DAT that must be ignored.
  task automatic gap(input int period);
    for (int k = 1; k < period; k++) drive(1'b0, 1'($urandom), 8'($urandom));
  endtask

  task automatic send_bytes(input int period, input int upto);
    for (int j = byte_cyc.size(); j < upto; j++) begin
      gap(period);
      drive(1'b1, 1'b1, frm_q[j]);
      byte_cyc.push_back(cyc + 1);
    end
  endtask

  task automatic send_eof(input int period);
    gap(period);
    drive(1'b1, 1'b0, 8'($urandom));
    eof_cyc = cyc + 1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(1'b1, 1'b0, 8'h00);
  endtask

  task automatic new_frame(input logic [47:0] dst, input logic [15:0] et);
    frm_q.delete();
    byte_cyc.delete();
    for (int i = 5; i >= 0; i--) frm_q.push_back(dst[8*i +: 8]);
    for (int i = 0; i < 6; i++) frm_q.push_back(8'($urandom));
    frm_q.push_back(et[15:8]);
    frm_q.push_back(et[7:0]);
  endtask

  task automatic add_rec(input logic [7:0] a, input logic [31:0] d);
    frm_q.push_back(a);
    for (int i = 3; i >= 0; i--) frm_q.push_back(d[8*i +: 8]);
  endtask

  task automatic add_pad(input int n);
    for (int i = 0; i < n; i++) frm_q.push_back(8'($urandom));
  endtask

  // Frame-level reference: decides the outcome from the whole byte list.
  function automatic void model_frame();
    int          len;
    int          n;
    int          base;
    logic [47:0] dst;
    logic [15:0] et;
    len = frm_q.size();
    if (len < 14) begin
      exp_evt.push_back(C_EV_ERR + eof_cyc);
      return;
    end
    dst = {frm_q[0], frm_q[1], frm_q[2], frm_q[3], frm_q[4], frm_q[5]};
    et  = {frm_q[12], frm_q[13]};
    if (!((dst == C_MY_MAC || dst == C_BCAST) && et == C_ET)) begin
      exp_drop++;
      return;
    end
    if (len < 15) begin
      exp_evt.push_back(C_EV_ERR + eof_cyc);
      return;
    end
    n = int'(frm_q[14]);
    for (int k = 0; k < n; k++) begin
      base = 15 + 5 * k;
      if (base + 4 >= len) begin
        exp_evt.push_back(C_EV_ERR + eof_cyc);
        return;
      end
      exp_addr.push_back(frm_q[base]);
      exp_data.push_back({frm_q[base+1], frm_q[base+2], frm_q[base+3], frm_q[base+4]});
      exp_wcyc.push_back(byte_cyc[base+4]);
    end
    exp_evt.push_back(C_EV_OK + eof_cyc);
  endfunction

  task automatic send_frame(input int period);
    send_bytes(period, frm_q.size());
    send_eof(period);
    model_frame();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_chk++;
    if ({o_busy, o_wr_en, o_wr_addr, o_wr_data, o_pkt_ok, o_pkt_err, o_drop_cnt} !== 60'd0) begin
      n_fail++;
      $display("FAIL reset_values: got busy=%b wr_en=%b addr=%h data=%h ok=%b err=%b drop=%0d, expected all zero",
               o_busy, o_wr_en, o_wr_addr, o_wr_data, o_pkt_ok, o_pkt_err, o_drop_cnt);
    end
    rst = 1'b0;
    idle(2);
  endtask

  task automatic test_valid_write(input int period, input string tag);
    clear_sb();
    new_frame(C_MY_MAC, C_ET);
    frm_q.push_back(8'd2);
    add_rec(8'h10, 32'hDEADBEEF);
    add_rec(8'h11, 32'h00000001);
    add_pad(8);
    send_frame(period);
    idle(6);
    n_chk++;
    if (got_wcyc.size() != exp_wcyc.size()) begin
      n_fail++;
      $display("FAIL %s_nwr: got %0d writes, expected %0d", tag, got_wcyc.size(), exp_wcyc.size());
    end
    for (int i = 0; i < got_wcyc.size() && i < exp_wcyc.size(); i++) begin
      n_chk++;
      if (got_addr[i] !== exp_addr[i] || got_data[i] !== exp_data[i] || got_wcyc[i] != exp_wcyc[i]) begin
        n_fail++;
        $display("FAIL %s_wr%0d: got %h/%h @%0d, expected %h/%h @%0d", tag, i,
                 got_addr[i], got_data[i], got_wcyc[i], exp_addr[i], exp_data[i], exp_wcyc[i]);
      end
    end
    n_chk++;
    if (got_evt.size() != 1 || got_evt[0] != exp_evt[0]) begin
      n_fail++;
      $display("FAIL %s_pkt_ok: got %0d end events, expected PKT_OK at cycle %0d", tag, got_evt.size(), eof_cyc);
    end
    n_chk++;
    if (!busy_seen || busy_first != byte_cyc[0] || busy_last != eof_cyc - 1) begin
      n_fail++;
      $display("FAIL %s_busy: got %0d..%0d, expected %0d..%0d", tag, busy_first, busy_last, byte_cyc[0], eof_cyc - 1);
    end
    n_chk++;
    if (hold_viol != 0 || o_drop_cnt !== 16'(exp_drop)) begin
      n_fail++;
      $display("FAIL %s_hold_drop: got hold_viol=%0d drop=%0d, expected 0 and %0d", tag, hold_viol, o_drop_cnt, exp_drop);
    end
  endtask

  task automatic test_drop();
    int drop0;
    clear_sb();
    drop0 = exp_drop;
    new_frame(C_MY_MAC, 16'h0800);
    frm_q.push_back(8'd1);
    add_rec(8'h20, 32'h12345678);
    send_frame(1);
    idle(2);
    new_frame(48'h0250C2AE4001, C_ET);
    frm_q.push_back(8'd1);
    add_rec(8'h21, 32'h9ABCDEF0);
    send_frame(1);
    idle(2);
    new_frame(C_BCAST, C_ET);
    frm_q.push_back(8'd1);
    add_rec(8'h22, 32'($urandom));
    add_pad(3);
    send_frame(1);
    idle(6);
    n_chk++;
    if (o_drop_cnt !== 16'(drop0 + 2) || exp_drop != drop0 + 2) begin
      n_fail++;
      $display("FAIL drop_count: got %0d, expected %0d", o_drop_cnt, drop0 + 2);
    end
    n_chk++;
    if (got_wcyc.size() != 1 || exp_wcyc.size() != 1) begin
      n_fail++;
      $display("FAIL drop_nwr: got %0d writes, expected 1", got_wcyc.size());
    end else begin
      n_chk++;
      if (got_addr[0] !== exp_addr[0] || got_data[0] !== exp_data[0] || got_wcyc[0] != exp_wcyc[0]) begin
        n_fail++;
        $display("FAIL bcast_wr: got %h/%h @%0d, expected %h/%h @%0d",
                 got_addr[0], got_data[0], got_wcyc[0], exp_addr[0], exp_data[0], exp_wcyc[0]);
      end
    end
    n_chk++;
    if (got_evt.size() != 1 || got_evt[0] != exp_evt[0]) begin
      n_fail++;
      $display("FAIL drop_events: got %0d end events, expected only PKT_OK at %0d", got_evt.size(), eof_cyc);
    end
  endtask

  task automatic test_truncate();
    clear_sb();
    new_frame(C_MY_MAC, C_ET);
    frm_q.push_back(8'd3);
    add_rec(8'h30, 32'($urandom));
    add_rec(8'h31, 32'($urandom));
    frm_q.push_back(8'h32);
    frm_q.push_back(8'hAA);
    send_frame(1);
    idle(2);
    new_frame(C_MY_MAC, C_ET);
    while (frm_q.size() > 10) void'(frm_q.pop_back());
    send_frame(1);
    idle(6);
    n_chk++;
    if (got_wcyc.size() != 2 || exp_wcyc.size() != 2) begin
      n_fail++;
      $display("FAIL trunc_nwr: got %0d writes, expected 2", got_wcyc.size());
    end else begin
      for (int i = 0; i < 2; i++) begin
        n_chk++;
        if (got_addr[i] !== exp_addr[i] || got_data[i] !== exp_data[i] || got_wcyc[i] != exp_wcyc[i]) begin
          n_fail++;
          $display("FAIL trunc_wr%0d: got %h/%h @%0d, expected %h/%h @%0d", i,
                   got_addr[i], got_data[i], got_wcyc[i], exp_addr[i], exp_data[i], exp_wcyc[i]);
        end
      end
    end
    n_chk++;
    if (got_evt.size() != 2 || exp_evt.size() != 2 || got_evt[0] != exp_evt[0] || got_evt[1] != exp_evt[1]) begin
      n_fail++;
      $display("FAIL trunc_err: got %0d end events, expected two PKT_ERR", got_evt.size());
    end
    n_chk++;
    if (o_drop_cnt !== 16'(exp_drop)) begin
      n_fail++;
      $display("FAIL runt_drop: got %0d, expected %0d", o_drop_cnt, exp_drop);
    end
  endtask

  task automatic test_random();
    int          sel;
    int          n;
    int          len;
    int          period;
    logic [47:0] dst;
    clear_sb();
    for (int f = 0; f < 16; f++) begin
      sel = $urandom_range(0, 2);
      dst = (sel == 0) ? C_MY_MAC : (sel == 1) ? C_BCAST : {8'h02, 8'($urandom), 32'($urandom)};
      new_frame(dst, ($urandom_range(0, 4) == 0) ? 16'h0800 : C_ET);
      n = $urandom_range(0, 6);
      frm_q.push_back(8'(n));
      for (int r = 0; r < n; r++) add_rec(8'($urandom), 32'($urandom));
      add_pad($urandom_range(0, 6));
      if ($urandom_range(0, 3) == 0) begin
        len = $urandom_range(1, frm_q.size() - 1);
        while (frm_q.size() > len) void'(frm_q.pop_back());
      end
      period = $urandom_range(1, 3);
      send_frame(period);
      idle($urandom_range(0, 2));
    end
    idle(6);
    n_chk++;
    if (got_wcyc.size() != exp_wcyc.size()) begin
      n_fail++;
      $display("FAIL rand_nwr: got %0d writes, expected %0d", got_wcyc.size(), exp_wcyc.size());
    end
    for (int i = 0; i < got_wcyc.size() && i < exp_wcyc.size(); i++) begin
      n_chk++;
      if (got_addr[i] !== exp_addr[i] || got_data[i] !== exp_data[i] || got_wcyc[i] != exp_wcyc[i]) begin
        n_fail++;
        $display("FAIL rand_wr%0d: got %h/%h @%0d, expected %h/%h @%0d", i,
                 got_addr[i], got_data[i], got_wcyc[i], exp_addr[i], exp_data[i], exp_wcyc[i]);
      end
    end
    n_chk++;
    if (got_evt.size() != exp_evt.size()) begin
      n_fail++;
      $display("FAIL rand_nevt: got %0d end events, expected %0d", got_evt.size(), exp_evt.size());
    end
    for (int i = 0; i < got_evt.size() && i < exp_evt.size(); i++) begin
      n_chk++;
      if (got_evt[i] != exp_evt[i]) begin
        n_fail++;
        $display("FAIL rand_evt%0d: got kind %0d @%0d, expected kind %0d @%0d", i,
                 got_evt[i] >> 24, got_evt[i] & 24'hFFFFFF, exp_evt[i] >> 24, exp_evt[i] & 24'hFFFFFF);
      end
    end
    n_chk++;
    if (o_drop_cnt !== 16'(exp_drop) || hold_viol != 0) begin
      n_fail++;
      $display("FAIL rand_drop_hold: got drop=%0d hold_viol=%0d, expected %0d and 0", o_drop_cnt, hold_viol, exp_drop);
    end
  endtask

  task automatic test_reset_midframe();
    clear_sb();
    new_frame(C_MY_MAC, C_ET);
    frm_q.push_back(8'd2);
    add_rec(8'h40, 32'hCAFEF00D);
    add_rec(8'h41, 32'h55AA55AA);
    send_bytes(1, 22);
    @(posedge clk);
    #2;
    rst = 1'b1;
    i_eth_stream = {2'b11, frm_q[22]};
    @(posedge clk);
    #1;
    n_chk++;
    if ({o_busy, o_wr_en, o_wr_addr, o_wr_data, o_pkt_ok, o_pkt_err, o_drop_cnt} !== 60'd0) begin
      n_fail++;
      $display("FAIL midreset_values: got busy=%b wr_en=%b addr=%h data=%h ok=%b err=%b drop=%0d, expected all zero",
               o_busy, o_wr_en, o_wr_addr, o_wr_data, o_pkt_ok, o_pkt_err, o_drop_cnt);
    end
    rst = 1'b0;
    i_eth_stream = 10'h200;
    exp_drop = 0;
    idle(4);
    n_chk++;
    if (got_wcyc.size() != 1 || got_addr[0] !== 8'h40 || got_data[0] !== 32'hCAFEF00D || got_wcyc[0] != byte_cyc[19]) begin
      n_fail++;
      $display("FAIL midreset_wr: got %0d writes, expected one write 40/cafef00d @%0d", got_wcyc.size(), byte_cyc[19]);
    end
    n_chk++;
    if (got_evt.size() != 0 || o_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_evt: got %0d end events busy=%b, expected 0 and 0", got_evt.size(), o_busy);
    end
  endtask

  task automatic test_back_to_back();
    clear_sb();
    new_frame(C_MY_MAC, C_ET);
    frm_q.push_back(8'd0);
    add_pad(4);
    send_frame(1);
    idle(4);
    n_chk++;
    if (got_wcyc.size() != 0 || got_evt.size() != 1 || got_evt[0] != C_EV_OK + eof_cyc) begin
      n_fail++;
      $display("FAIL n0_frame: got %0d writes %0d events, expected 0 writes and PKT_OK @%0d",
               got_wcyc.size(), got_evt.size(), eof_cyc);
    end
    new_frame(C_MY_MAC, C_ET);
    frm_q.push_back(8'd1);
    add_rec(8'h50, 32'($urandom));
    send_frame(1);
    new_frame(C_BCAST, C_ET);
    frm_q.push_back(8'd1);
    add_rec(8'h51, 32'($urandom));
    add_pad(2);
    send_frame(1);
    idle(6);
    n_chk++;
    if (got_wcyc.size() != 2 || exp_wcyc.size() != 2) begin
      n_fail++;
      $display("FAIL b2b_nwr: got %0d writes, expected 2", got_wcyc.size());
    end else begin
      for (int i = 0; i < 2; i++) begin
        n_chk++;
        if (got_addr[i] !== exp_addr[i] || got_data[i] !== exp_data[i] || got_wcyc[i] != exp_wcyc[i]) begin
          n_fail++;
          $display("FAIL b2b_wr%0d: got %h/%h @%0d, expected %h/%h @%0d", i,
                   got_addr[i], got_data[i], got_wcyc[i], exp_addr[i], exp_data[i], exp_wcyc[i]);
        end
      end
    end
    n_chk++;
    if (got_evt.size() != 3 || exp_evt.size() != 3 || got_evt[1] != exp_evt[1] || got_evt[2] != exp_evt[2]) begin
      n_fail++;
      $display("FAIL b2b_evt: got %0d end events, expected 3 PKT_OK", got_evt.size());
    end
  endtask

  initial begin
    test_reset();
    test_valid_write(1, "valid");
    test_drop();
    test_truncate();
    test_valid_write(10, "throttled");
    test_random();
    test_reset_midframe();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
